// File: rtl/fifo_flags.sv
// Synchronous first-word-fall-through FIFO with occupancy count and programmable almost-full/almost-empty flags.
// Sticky overflow/underflow registers are built only when FIFO_ERR_FLAGS_EN is defined; otherwise those outputs are tied to 0.
module fifo_flags #(
    parameter int NB_DATA         = 8,
    parameter int PTR_LEN         = 4,
    parameter int ALMOST_FULL_TH  = 12,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_clear,
    input  logic               i_write_fifo,
    input  logic [NB_DATA-1:0] i_data_to_write,
    input  logic               i_read_fifo,
    output logic [NB_DATA-1:0] o_data_to_read,
    output logic               o_fifo_is_empty,
    output logic               o_fifo_is_full,
    output logic               o_almost_full,
    output logic               o_almost_empty,
    output logic [PTR_LEN:0]   o_count,
    output logic               o_overflow,
    output logic               o_underflow
);

    localparam int             DEPTH     = 2 ** PTR_LEN;
    localparam logic [PTR_LEN:0] DEPTH_CNT = (PTR_LEN + 1)'(DEPTH);
    localparam logic [PTR_LEN:0] AF_TH     = (PTR_LEN + 1)'(ALMOST_FULL_TH);
    localparam logic [PTR_LEN:0] AE_TH     = (PTR_LEN + 1)'(ALMOST_EMPTY_TH);

    logic [NB_DATA-1:0] mem [DEPTH];
    logic [PTR_LEN-1:0] wptr;
    logic [PTR_LEN-1:0] rptr;
    logic [PTR_LEN:0]   count;
    logic               empty;
    logic               full;
    logic               rd_ok;
    logic               wr_ok;

    assign empty = (count == '0);
    assign full  = (count == DEPTH_CNT);
    // A full FIFO still accepts a write when a pop frees a slot in the same cycle.
    assign rd_ok = i_read_fifo & ~empty;
    assign wr_ok = i_write_fifo & (~full | rd_ok);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (i_clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_ok)
                wptr <= wptr + 1'b1;
            if (rd_ok)
                rptr <= rptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; reset and flush are gated so a coinciding write is dropped.
    always_ff @(posedge i_clk) begin
        if (wr_ok && !i_clear && !i_reset)
            mem[wptr] <= i_data_to_write;
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (i_clear) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (i_write_fifo && !wr_ok)
                overflow_q <= 1'b1;
            if (i_read_fifo && empty)
                underflow_q <= 1'b1;
        end
    end

    assign o_overflow  = overflow_q;
    assign o_underflow = underflow_q;
`else
    assign o_overflow  = 1'b0;
    assign o_underflow = 1'b0;
`endif

    assign o_data_to_read  = mem[rptr];
    assign o_count         = count;
    assign o_fifo_is_empty = empty;
    assign o_fifo_is_full  = full;
    assign o_almost_full   = (count >= AF_TH);
    assign o_almost_empty  = (count <= AE_TH);

endmodule

// File: tb/tb_fifo_flags.sv
// Bench for fifo_flags: queue-based reference model checked every cycle, plus directed literal checks.
module tb_fifo_flags;

    localparam int DEPTH = 16;
`ifdef FIFO_ERR_FLAGS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       wr  = 1'b0;
    logic [7:0] din = 8'h00;
    logic       rd  = 1'b0;
    logic [7:0] dout;
    logic       empty, full, afull, aempty, ovf, udf;
    logic [4:0] count;

    int checks   = 0;
    int failures = 0;

    fifo_flags #(
        .NB_DATA(8), .PTR_LEN(4), .ALMOST_FULL_TH(12), .ALMOST_EMPTY_TH(2)
    ) dut (
        .i_clk(clk),
        .i_reset(rst),
        .i_clear(clr),
        .i_write_fifo(wr),
        .i_data_to_write(din),
        .i_read_fifo(rd),
        .o_data_to_read(dout),
        .o_fifo_is_empty(empty),
        .o_fifo_is_full(full),
        .o_almost_full(afull),
        .o_almost_empty(aempty),
        .o_count(count),
        .o_overflow(ovf),
        .o_underflow(udf)
    );

    always #5 clk = ~clk;

    // Reference model: a plain queue plus sticky error bits.
    logic [7:0] m_q[$];
    bit         m_ovf = 1'b0;
    bit         m_udf = 1'b0;
    bit         m_rd, m_wr;

    always @(posedge clk or posedge rst) begin
        if (rst || clr) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            m_rd = rd && (m_q.size() > 0);
            m_wr = wr && ((m_q.size() < DEPTH) || m_rd);
            if (rd && m_q.size() == 0) m_udf = 1'b1;
            if (wr && !m_wr)           m_ovf = 1'b1;
            if (m_rd) void'(m_q.pop_front());
            if (m_wr) m_q.push_back(din);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("m_count",  32'(count),  32'(m_q.size()));
        chk("m_empty",  32'(empty),  32'(m_q.size() == 0));
        chk("m_full",   32'(full),   32'(m_q.size() == DEPTH));
        chk("m_afull",  32'(afull),  32'(m_q.size() >= 12));
        chk("m_aempty", 32'(aempty), 32'(m_q.size() <= 2));
        chk("m_ovf",    32'(ovf),    32'(ERR_EN & m_ovf));
        chk("m_udf",    32'(udf),    32'(ERR_EN & m_udf));
        if (m_q.size() > 0)
            chk("m_head", 32'(dout), 32'(m_q[0]));
    end

    task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
        @(negedge clk);
        #1;
        wr = w; din = d; rd = r; clr = c;
        @(posedge clk);
        #1;
        wr = 1'b0; rd = 1'b0; clr = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_empty",  32'(empty),  32'd1);
        chk("rst_full",   32'(full),   32'd0);
        chk("rst_afull",  32'(afull),  32'd0);
        chk("rst_aempty", 32'(aempty), 32'd1);
        chk("rst_count",  32'(count),  32'd0);
        chk("rst_ovf",    32'(ovf),    32'd0);
        chk("rst_udf",    32'(udf),    32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Fill to full, then overflow attempt
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0);
            chk("fill_count", 32'(count), 32'(i + 1));
            chk("fill_afull", 32'(afull), 32'(i + 1 >= 12));
            chk("fill_head",  32'(dout),  32'd0);
        end
        chk("fill_full", 32'(full), 32'd1);
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        chk("ovf_count", 32'(count), 32'd16);
        chk("ovf_flag",  32'(ovf),   32'(ERR_EN));

        // Drain in order, then underflow attempt
        for (int i = 0; i < 16; i++) begin
            chk("drain_data", 32'(dout), 32'(i));
            step(1'b0, 8'h00, 1'b1, 1'b0);
            chk("drain_count",  32'(count),  32'(15 - i));
            chk("drain_aempty", 32'(aempty), 32'(15 - i <= 2));
        end
        chk("drain_empty", 32'(empty), 32'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("udf_count", 32'(count), 32'd0);
        chk("udf_flag",  32'(udf),   32'(ERR_EN));
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr_ovf", 32'(ovf), 32'd0);
        chk("clr_udf", 32'(udf), 32'd0);

        // Wrap-around of both pointers
        for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
        chk("wrap_count", 32'(count), 32'd10);
        for (int i = 0; i < 10; i++) begin
            chk("wrap_data", 32'(dout), 32'(8'h50 + i));
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("wrap_end", 32'(count), 32'd0);

        // Simultaneous read/write while empty
        step(1'b1, 8'h77, 1'b1, 1'b0);
        chk("rw0_count", 32'(count), 32'd1);
        chk("rw0_head",  32'(dout),  32'h77);
        chk("rw0_udf",   32'(udf),   32'(ERR_EN));
        step(1'b0, 8'h00, 1'b1, 1'b1);

        // Simultaneous read/write while full
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        step(1'b1, 8'hC0, 1'b1, 1'b0);
        chk("rwf_count", 32'(count), 32'd16);
        chk("rwf_full",  32'(full),  32'd1);
        chk("rwf_ovf",   32'(ovf),   32'd0);
        for (int i = 1; i < 16; i++) begin
            chk("rwf_data", 32'(dout), 32'(8'h80 + i));
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("rwf_last", 32'(dout), 32'hC0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Flush at count 7 with write and read asserted and sticky flag set
        step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        chk("pre_clr_count", 32'(count), 32'd7);
        chk("pre_clr_udf",   32'(udf),   32'(ERR_EN));
        step(1'b1, 8'hEE, 1'b1, 1'b1);
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_empty", 32'(empty), 32'd1);
        chk("clr_udf2",  32'(udf),   32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("clr_hold", 32'(count), 32'd0);
        step(1'b1, 8'h11, 1'b0, 1'b0);
        chk("post_clr_head", 32'(dout), 32'h11);

        // Async reset pulse between edges
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'h12, 1'b0, 1'b0);
        step(1'b1, 8'h13, 1'b0, 1'b0);
        chk("pre_rst_count", 32'(count), 32'd2);
        #1 rst = 1'b1;
        #1;
        chk("arst_count",  32'(count),  32'd0);
        chk("arst_empty",  32'(empty),  32'd1);
        chk("arst_aempty", 32'(aempty), 32'd1);
        chk("arst_udf",    32'(udf),    32'd0);
        #1 rst = 1'b0;

        // Reset held across an edge drops the coinciding write
        @(negedge clk);
        #1;
        rst = 1'b1; wr = 1'b1; din = 8'h33;
        @(posedge clk);
        #1;
        rst = 1'b0; wr = 1'b0;
        chk("rstw_count", 32'(count), 32'd0);
        chk("rstw_empty", 32'(empty), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("rstw_hold", 32'(count), 32'd0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_flags.md
# fifo_flags

Parametrised synchronous FIFO: the next generation of the UART RX/TX buffer. It adds an occupancy count, programmable almost-full and almost-empty thresholds, a synchronous flush, and optional sticky overflow/underflow error flags. It sits between the UART RX/TX engines and the ALU interface. One clock domain, first-word-fall-through read port.

## Interface
Parameters:
- NB_DATA, 8, data word width
- PTR_LEN, 4, pointer width; depth DEPTH = 2**PTR_LEN
- ALMOST_FULL_TH, 12, o_almost_full asserts when count >= this (1..DEPTH)
- ALMOST_EMPTY_TH, 2, o_almost_empty asserts when count <= this (0..DEPTH-1)

Ports:
- i_clk  in  1  clock, rising edge
- i_reset  in  1  reset; one clock; reset is asynchronous and active-high
- i_clear  in  1  synchronous flush
- i_write_fifo  in  1  write request
- i_data_to_write  in  NB_DATA  write data
- i_read_fifo  in  1  read request (pop)
- o_data_to_read  out  NB_DATA  head-of-queue word
- o_fifo_is_empty  out  1  count == 0
- o_fifo_is_full  out  1  count == DEPTH
- o_almost_full  out  1  count >= ALMOST_FULL_TH
- o_almost_empty  out  1  count <= ALMOST_EMPTY_TH
- o_count  out  PTR_LEN+1  occupancy, 0..DEPTH
- o_overflow  out  1  sticky: write attempted while full and not accepted
- o_underflow  out  1  sticky: read attempted while empty

## Operation
- Storage is a DEPTH x NB_DATA register array. Write pointer and read pointer are PTR_LEN bits each and wrap modulo DEPTH. The count register is PTR_LEN+1 bits.
- Acceptance is evaluated on registered state at the rising edge:
  - wr_ok = i_write_fifo & (~full | rd_ok)
  - rd_ok = i_read_fifo & ~empty
- On wr_ok: array[wptr] <= data, then wptr+1.
- On rd_ok: rptr+1.
- Count update:
  - wr_ok only: +1
  - rd_ok only: -1
  - both: unchanged
- Simultaneous read and write:
  - Empty: write accepted, read rejected (underflow), count becomes 1.
  - Full: both accepted, count stays DEPTH, full stays asserted.
  - Otherwise: both pointers advance, count unchanged.
- Write while full with no read: data discarded, no state change, o_overflow set.
- Read while empty: no state change, o_underflow set, even if a write is accepted in the same cycle.
- i_clear has priority over read and write. It zeroes both pointers and the count and clears the sticky flags. Array contents are don't-care.
- All flags are decoded from the registered next count: empty, full, almost_full, almost_empty.
- o_data_to_read = array[rptr], combinational from the registered pointer. It is valid only while ~o_fifo_is_empty; otherwise its value is undefined (stale).
- Sticky flags clear only on i_reset or i_clear.

## Timing
- Reset values (async, immediate):
  - pointers and count = 0
  - o_fifo_is_empty = 1, o_fifo_is_full = 0
  - o_almost_full = 0 (ALMOST_FULL_TH >= 1)
  - o_almost_empty = 1
  - o_overflow = 0, o_underflow = 0
- Write latency: data written at edge N appears on o_data_to_read after edge N if the FIFO was empty. o_fifo_is_empty falls at the same edge.
- Read latency: pop at edge N; the next word is on o_data_to_read after edge N, with no bubble.
- All status outputs change only on i_clk edges or async reset; there are no combinational paths from inputs to outputs.
- Reset asserted mid-operation aborts the operation immediately. A write in progress at the edge coinciding with reset is not stored.
- Throughput: one write and one read per cycle, sustained.

## Configuration
- FIFO_ERR_FLAGS_EN
  - Defined: the o_overflow and o_underflow sticky registers are implemented as described above.
  - Undefined: both outputs are tied to 0, no registers are inferred, and all other behaviour is identical.

## Test plan
- Reset then 16 writes 0x00..0x0F, no reads:
  - o_count steps 1..16
  - o_almost_full rises on the edge where count reaches 12
  - o_fifo_is_full = 1 after the 16th write
  - a 17th write of 0xAA is discarded, o_overflow = 1 (with macro)
- Drain the full FIFO with 16 reads:
  - o_data_to_read presents 0x00..0x0F in order
  - o_almost_empty rises at count 2
  - o_fifo_is_empty = 1 at count 0
  - an extra read sets o_underflow = 1 and leaves count 0
- Wrap-around: 10 writes, 10 reads, 10 more writes 0x50..0x59:
  - pointers wrap past 15
  - reads return 0x50..0x59, count returns to 0
- Simultaneous read and write at count 0:
  - count becomes 1, head = write data, o_underflow = 1
- Simultaneous read and write at count 16:
  - count stays 16, full stays 1, no overflow
  - read order remains FIFO
- Mid-stream i_clear with write and read also asserted at count 7:
  - count becomes 0, empty = 1
  - sticky flags cleared
  - no word from that cycle stored
- Async i_reset pulse between edges:
  - all outputs return to reset values before the next edge
